// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive engine: state encoding, parity
// encodings, legal prescale values and the majority-vote helper.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_STOP2  = 3'd5,
        ST_BREAK  = 3'd6
    } rx_state_e;

    typedef enum logic {
        PARITY_EVEN = 1'b0,
        PARITY_ODD  = 1'b1
    } parity_type_e;

    localparam int unsigned PRESCALE_8       = 32'd8;
    localparam int unsigned PRESCALE_16      = 32'd16;
    localparam int unsigned PRESCALE_32      = 32'd32;
    localparam int unsigned PRESCALE_DEFAULT = PRESCALE_16;

    function automatic logic majority3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

endpackage

// File: rtl/uart_rx_frame_engine_if.sv
// Receive-side report bundle: the engine drives it (master), the FIFO /
// register-file side consumes it (slave).
interface uart_rx_frame_engine_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] parallel_data;
    logic                  data_valid;
    logic                  parity_error;
    logic                  framing_error;
    logic                  busy;

    modport master (
        output parallel_data, data_valid, parity_error, framing_error, busy
    );

    modport slave (
        input  parallel_data, data_valid, parity_error, framing_error, busy
    );
endinterface

// File: rtl/uart_rx_sampler.sv
// Captures the line at the three mid-bit edges (P/2-2, P/2-1, P/2) and
// presents their majority for the decision edge.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [PRESCALE_WIDTH-1:0] edge_cnt_i,
    input  logic [PRESCALE_WIDTH-1:0] half_i,
    input  logic                      rx_i,
    output logic                      vote_o
);

    logic [2:0] samples_q;

    // Sample capture; each slot is overwritten once per bit period.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            samples_q <= 3'b000;
        end else begin
            if (edge_cnt_i == half_i - PRESCALE_WIDTH'(2)) samples_q[0] <= rx_i;
            if (edge_cnt_i == half_i - PRESCALE_WIDTH'(1)) samples_q[1] <= rx_i;
            if (edge_cnt_i == half_i)                      samples_q[2] <= rx_i;
        end
    end

    assign vote_o = majority3(samples_q);

endmodule

// File: rtl/uart_rx_frame_engine.sv
// UART receive frame engine: start detect, majority-voted bit decisions,
// LSB-first deserialisation, parity and stop checking with pulse reporting.
// Optional second stop bit is built only when UART_RX_TWO_STOP_EN is defined.
module uart_rx_frame_engine
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      serial_data_in,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    input  logic                      parity_enable,
    input  logic                      parity_type,
    input  logic                      stop_bits,
    uart_rx_frame_engine_if.master    rx_if
);

    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [PRESCALE_WIDTH-1:0] P_8   = PRESCALE_WIDTH'(PRESCALE_8);
    localparam logic [PRESCALE_WIDTH-1:0] P_16  = PRESCALE_WIDTH'(PRESCALE_16);
    localparam logic [PRESCALE_WIDTH-1:0] P_32  = PRESCALE_WIDTH'(PRESCALE_32);
    localparam logic [PRESCALE_WIDTH-1:0] P_DEF = PRESCALE_WIDTH'(PRESCALE_DEFAULT);
    localparam logic [BIT_W-1:0]          LAST_BIT = BIT_W'(DATA_WIDTH - 1);

    rx_state_e                 state_q;
    logic [PRESCALE_WIDTH-1:0] cnt_q;
    logic [PRESCALE_WIDTH-1:0] p_q;
    logic [BIT_W-1:0]          bit_idx_q;
    logic [DATA_WIDTH-1:0]     shadow_q;
    logic [DATA_WIDTH-1:0]     data_q;
    logic                      par_en_q;
    parity_type_e              par_type_q;
    logic                      par_flag_q;
    logic                      dv_q;
    logic                      pe_q;
    logic                      fe_q;
    logic                      busy_q;

    logic [PRESCALE_WIDTH-1:0] p_legal_s;
    logic [PRESCALE_WIDTH-1:0] half_s;
    logic                      at_dec_s;
    logic                      at_last_s;
    logic                      vote_s;
    logic                      two_stop_s;
    logic                      par_exp_s;

    // Any prescale outside 8/16/32 runs at 16 so a bad setting cannot stall the counter.
    assign p_legal_s = ((prescale == P_8) || (prescale == P_16) || (prescale == P_32))
                       ? prescale : P_DEF;
    assign half_s    = p_q >> 1;
    assign at_dec_s  = (cnt_q == half_s + PRESCALE_WIDTH'(1));
    assign at_last_s = (cnt_q == p_q - PRESCALE_WIDTH'(1));
    assign par_exp_s = (^shadow_q) ^ (par_type_q == PARITY_ODD);

`ifdef UART_RX_TWO_STOP_EN
    logic stop_bits_q;

    // Stop-bit count is frozen at start detection like the other frame settings.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stop_bits_q <= 1'b0;
        end else if ((state_q == ST_IDLE) && !serial_data_in) begin
            stop_bits_q <= stop_bits;
        end
    end

    assign two_stop_s = stop_bits_q;
`else
    logic unused_stop_bits_s;
    assign unused_stop_bits_s = stop_bits;
    assign two_stop_s         = 1'b0;
`endif

    uart_rx_sampler #(
        .PRESCALE_WIDTH (PRESCALE_WIDTH)
    ) u_sampler (
        .clk        (clk),
        .reset      (reset),
        .edge_cnt_i (cnt_q),
        .half_i     (half_s),
        .rx_i       (serial_data_in),
        .vote_o     (vote_s)
    );

    // Frame state machine; report pulses default low and rise only on decision edges.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            p_q        <= P_DEF;
            bit_idx_q  <= '0;
            shadow_q   <= '0;
            data_q     <= '0;
            par_en_q   <= 1'b0;
            par_type_q <= PARITY_EVEN;
            par_flag_q <= 1'b0;
            dv_q       <= 1'b0;
            pe_q       <= 1'b0;
            fe_q       <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            dv_q  <= 1'b0;
            pe_q  <= 1'b0;
            fe_q  <= 1'b0;
            cnt_q <= at_last_s ? '0 : cnt_q + PRESCALE_WIDTH'(1);
            case (state_q)
                ST_IDLE: begin
                    cnt_q <= '0;
                    if (!serial_data_in) begin
                        state_q    <= ST_START;
                        busy_q     <= 1'b1;
                        p_q        <= p_legal_s;
                        par_en_q   <= parity_enable;
                        par_type_q <= parity_type_e'(parity_type);
                        par_flag_q <= 1'b0;
                        bit_idx_q  <= '0;
                    end
                end
                ST_START: begin
                    if (at_dec_s && vote_s) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else if (at_last_s) begin
                        state_q <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (at_dec_s) shadow_q[bit_idx_q] <= vote_s;
                    if (at_last_s) begin
                        if (bit_idx_q == LAST_BIT) begin
                            state_q <= par_en_q ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + BIT_W'(1);
                        end
                    end
                end
                ST_PARITY: begin
                    if (at_dec_s && (vote_s != par_exp_s)) par_flag_q <= 1'b1;
                    if (at_last_s) state_q <= ST_STOP;
                end
                // Single stop bit finishes at the decision edge, half a bit early.
                ST_STOP: begin
                    if (at_dec_s) begin
                        if (!vote_s) begin
                            fe_q    <= 1'b1;
                            state_q <= ST_BREAK;
                        end else if (!two_stop_s) begin
                            if (par_flag_q) begin
                                pe_q <= 1'b1;
                            end else begin
                                dv_q   <= 1'b1;
                                data_q <= shadow_q;
                            end
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else if (at_last_s && two_stop_s) begin
                        state_q <= ST_STOP2;
                    end
                end
`ifdef UART_RX_TWO_STOP_EN
                ST_STOP2: begin
                    if (at_dec_s) begin
                        if (!vote_s) begin
                            fe_q    <= 1'b1;
                            state_q <= ST_BREAK;
                        end else begin
                            if (par_flag_q) begin
                                pe_q <= 1'b1;
                            end else begin
                                dv_q   <= 1'b1;
                                data_q <= shadow_q;
                            end
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
`endif
                ST_BREAK: begin
                    cnt_q <= '0;
                    if (serial_data_in) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rx_if.parallel_data = data_q;
    assign rx_if.data_valid    = dv_q;
    assign rx_if.parity_error  = pe_q;
    assign rx_if.framing_error = fe_q;
    assign rx_if.busy          = busy_q;

endmodule

// File: tb/tb_uart_rx_frame_engine.sv
// Directed plus randomized frames against a frame-level outcome model.
module tb_uart_rx_frame_engine;

    logic       clk = 1'b0;
    logic       reset;
    logic       line;
    logic [5:0] prescale;
    logic       parity_enable;
    logic       parity_type;
    logic       stop_bits;

    int checks = 0;
    int errors = 0;
    int dv_cnt = 0, pe_cnt = 0, fe_cnt = 0;
    int dv_base = 0, pe_base = 0, fe_base = 0;
    logic [7:0] rx_words [256];
    logic [7:0] last_good;

    uart_rx_frame_engine_if #(.DATA_WIDTH(8)) rx_if ();

    uart_rx_frame_engine #(
        .DATA_WIDTH     (8),
        .PRESCALE_WIDTH (6)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .serial_data_in (line),
        .prescale       (prescale),
        .parity_enable  (parity_enable),
        .parity_type    (parity_type),
        .stop_bits      (stop_bits),
        .rx_if          (rx_if)
    );

    always #5 clk = ~clk;

    // Pulse monitor: counts every high cycle so a stretched pulse shows up as extra.
    always @(negedge clk) begin
        if (rx_if.data_valid) begin
            rx_words[dv_cnt & 255] <= rx_if.parallel_data;
            dv_cnt <= dv_cnt + 1;
        end
        if (rx_if.parity_error)  pe_cnt <= pe_cnt + 1;
        if (rx_if.framing_error) fe_cnt <= fe_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bits(input logic b, input int n);
        line = b;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input int p, input bit pen, input bit ptype,
                              input bit par_bit, input bit s1, input bit s2, input bit two,
                              input int tail_low, input int gap);
        parity_enable = pen;
        parity_type   = ptype;
        drive_bits(1'b0, p);
        for (int i = 0; i < 8; i++) drive_bits(d[i], p);
        if (pen) drive_bits(par_bit, p);
        drive_bits(s1, p);
        if (two) drive_bits(s2, p);
        if (tail_low > 0) begin
            drive_bits(1'b0, tail_low);
            check("break_busy", {31'd0, rx_if.busy}, 32'd1);
        end
        drive_bits(1'b1, gap);
    endtask

    // Frame-level outcome from the line contents alone.
    task automatic expect_frame(input string tag, input logic [7:0] d, input bit pen, input bit ptype,
                                input bit par_bit, input bit s1, input bit s2, input bit two);
        int  want_par;
        bit  exp_fe, exp_pe, exp_dv;
        want_par = ($countones(d) + int'(ptype)) % 2;
        exp_fe   = (s1 == 1'b0) || (two && (s2 == 1'b0));
        exp_pe   = !exp_fe && pen && (int'(par_bit) != want_par);
        exp_dv   = !exp_fe && !exp_pe;
        check({tag, "_dv"}, dv_cnt - dv_base, {31'd0, exp_dv});
        check({tag, "_pe"}, pe_cnt - pe_base, {31'd0, exp_pe});
        check({tag, "_fe"}, fe_cnt - fe_base, {31'd0, exp_fe});
        if (exp_dv) begin
            check({tag, "_word"}, {24'd0, rx_words[dv_base & 255]}, {24'd0, d});
            last_good = d;
        end
        check({tag, "_pd"}, {24'd0, rx_if.parallel_data}, {24'd0, last_good});
        check({tag, "_busy"}, {31'd0, rx_if.busy}, 32'd0);
        dv_base = dv_cnt;
        pe_base = pe_cnt;
        fe_base = fe_cnt;
    endtask

    initial begin
        int  p, good;
        bit  pen, ptype, par_bit, s1, s2, sb, two;
        logic [7:0] d;

        reset = 1'b0;
        line = 1'b1;
        prescale = 6'd16;
        parity_enable = 1'b0;
        parity_type = 1'b0;
        stop_bits = 1'b0;
        last_good = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_pd",   {24'd0, rx_if.parallel_data}, 32'd0);
        check("rst_dv",   {31'd0, rx_if.data_valid},    32'd0);
        check("rst_pe",   {31'd0, rx_if.parity_error},  32'd0);
        check("rst_fe",   {31'd0, rx_if.framing_error}, 32'd0);
        check("rst_busy", {31'd0, rx_if.busy},          32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        prescale = 6'd8;
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 4);
        expect_frame("a5_p8", 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

        prescale = 6'd16;
        send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0, 4);
        expect_frame("bad_par", 8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);

        prescale = 6'd32;
        send_frame(8'h5A, 32, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 96, 4);
        expect_frame("break", 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        prescale = 6'd16;
        drive_bits(1'b0, 2);
        drive_bits(1'b1, 20);
        check("glitch_busy", {31'd0, rx_if.busy}, 32'd0);
        check("glitch_pulses", (dv_cnt - dv_base) + (pe_cnt - pe_base) + (fe_cnt - fe_base), 32'd0);

        prescale = 6'd8;
        send_frame(8'h01, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0);
        send_frame(8'hFE, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 4);
        check("b2b_count", dv_cnt - dv_base, 32'd2);
        check("b2b_first",  {24'd0, rx_words[dv_base & 255]},       32'h01);
        check("b2b_second", {24'd0, rx_words[(dv_base + 1) & 255]}, 32'hFE);
        check("b2b_err", (pe_cnt - pe_base) + (fe_cnt - fe_base), 32'd0);
        last_good = 8'hFE;
        dv_base = dv_cnt;
        check("b2b_pd", {24'd0, rx_if.parallel_data}, {24'd0, last_good});

        prescale = 6'd12;
        send_frame(8'h96, 16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 4);
        expect_frame("ill_p12", 8'h96, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        prescale = 6'd0;
        send_frame(8'h3A, 16, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 0, 4);
        expect_frame("ill_p0", 8'h3A, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);

        prescale = 6'd8;
        parity_enable = 1'b0;
        drive_bits(1'b0, 8);
        drive_bits(1'b1, 8);
        drive_bits(1'b0, 8);
        drive_bits(1'b1, 8);
        reset = 1'b0;
        #1;
        check("mid_rst_busy", {31'd0, rx_if.busy},          32'd0);
        check("mid_rst_pd",   {24'd0, rx_if.parallel_data}, 32'd0);
        check("mid_rst_dv",   {31'd0, rx_if.data_valid},    32'd0);
        check("mid_rst_err",  {30'd0, rx_if.parity_error, rx_if.framing_error}, 32'd0);
        @(negedge clk);
        drive_bits(1'b1, 3);
        reset = 1'b1;
        drive_bits(1'b1, 2);
        last_good = 8'h00;
        send_frame(8'h55, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 4);
        expect_frame("post_rst", 8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

`ifdef UART_RX_TWO_STOP_EN
        prescale = 6'd16;
        stop_bits = 1'b1;
        send_frame(8'h81, 16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 0, 4);
        expect_frame("stop2_bad", 8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        send_frame(8'hC3, 16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 0, 4);
        expect_frame("stop2_ok", 8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        stop_bits = 1'b0;
`endif

        for (int k = 0; k < 24; k++) begin
            case ($urandom_range(0, 2))
                0:       p = 8;
                1:       p = 16;
                default: p = 32;
            endcase
            d       = 8'($urandom);
            pen     = 1'($urandom_range(0, 1));
            ptype   = 1'($urandom_range(0, 1));
            good    = ($countones(d) + int'(ptype)) % 2;
            par_bit = 1'(good) ^ ($urandom_range(0, 3) == 0);
            s1      = ($urandom_range(0, 7) != 0);
            s2      = ($urandom_range(0, 7) != 0);
            sb      = 1'($urandom_range(0, 1));
`ifdef UART_RX_TWO_STOP_EN
            two     = sb;
`else
            two     = 1'b0;
`endif
            stop_bits = sb;
            prescale  = 6'(p);
            send_frame(d, p, pen, ptype, par_bit, s1, s2, two, 0, 3);
            expect_frame("rand", d, pen, ptype, par_bit, s1, s2, two);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
